msj_setpoint_scheduler: RTL and testbench

MSJ_SETPOINT_SCHEDULER -- requirements
Module: msj_setpoint_scheduler

---
 rtl/msj_setpoint_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_msj_setpoint_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msj_setpoint_scheduler.sv
// ---------------------------------------------------------------------------
// msj_setpoint_scheduler
//
// Holds a signed target and a signed output setpoint per motor channel.
// A tick counter paces periodic scans. Each scan visits one motor per
// cycle. During a visit the scan applies the button inputs to that motor's
// target, then moves sp toward the target, limited by max_step. Between
// scans, the host can overwrite any target through a valid/ready port.
//
// Ports
//   clock, reset          : single clock domain; synchronous active-high reset
//   host_valid/host_ready : host target write handshake (ready only in IDLE)
//   host_motor/host_value : write address and value (value clamped to limit)
//   host_err              : one-cycle strobe after an out-of-range write
//   max_step              : per-scan ramp limit, <= 0 means jump directly
//   pull_buttons          : active-low per-motor increment buttons
//   release_buttons       : active-low per-motor decrement buttons
//   release_all_button    : active-low global decrement
//   zero_pose_button      : active-low global zero
//   sp                    : flattened setpoints, motor i at [32i+31:32i]
//   sp_update             : per-motor strobe in the cycle after sp changed
//   busy                  : high while a scan is in progress
// ---------------------------------------------------------------------------
module msj_setpoint_scheduler #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int CLOCK_SPEED_HZ   = 50_000_000,
    parameter int STEP_RATE_HZ     = 100,
    parameter int BUTTON_STEP      = 10,
    parameter int SP_LIMIT         = 1_000_000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [7:0]                    host_motor,
    input  logic signed [31:0]            host_value,
    output logic                          host_err,
    input  logic signed [31:0]            max_step,
    input  logic [NUMBER_OF_MOTORS-1:0]   pull_buttons,
    input  logic [NUMBER_OF_MOTORS-1:0]   release_buttons,
    input  logic                          release_all_button,
    input  logic                          zero_pose_button,
    output logic [NUMBER_OF_MOTORS*32-1:0] sp,
    output logic [NUMBER_OF_MOTORS-1:0]   sp_update,
    output logic                          busy
);

    localparam int TICK_PERIOD = CLOCK_SPEED_HZ / STEP_RATE_HZ;
    localparam int CNT_W       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int IDX_W       = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;

    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_PERIOD - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUMBER_OF_MOTORS - 1);
    localparam logic signed [32:0] LIM_POS   = 33'(SP_LIMIT);
    localparam logic signed [32:0] LIM_NEG   = -33'(SP_LIMIT);
    localparam logic signed [31:0] LIM_POS32 = 32'(SP_LIMIT);
    localparam logic signed [31:0] LIM_NEG32 = -32'(SP_LIMIT);
    localparam logic signed [32:0] STEP33    = 33'(BUTTON_STEP);

    // A scan must finish, with one spare IDLE cycle, before the next tick.
    generate
        if (TICK_PERIOD <= NUMBER_OF_MOTORS + 1) begin : g_bad_tick_period
            $error("msj_setpoint_scheduler: tick period must exceed NUMBER_OF_MOTORS+1 cycles");
        end
    endgenerate

    // Folds a 33-bit intermediate back into the legal setpoint range.
    function automatic logic signed [31:0] saturate(input logic signed [32:0] v);
        if (v > LIM_POS) begin
            return LIM_POS32;
        end else if (v < LIM_NEG) begin
            return LIM_NEG32;
        end else begin
            return v[31:0];
        end
    endfunction

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic                   pending_reg, pending_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   step_tick;
    logic                   host_err_reg;
    logic [NUMBER_OF_MOTORS-1:0] sp_update_reg, sp_update_next;

    logic signed [31:0] target_reg [NUMBER_OF_MOTORS];
    logic signed [31:0] sp_reg     [NUMBER_OF_MOTORS];

    logic signed [31:0] cur_target, cur_sp, new_target, new_sp;
    logic signed [32:0] diff, abs_diff;
    logic               host_accept, host_ok;

    // ---------------- tick counter ----------------
    assign step_tick = (cnt_reg == TICK_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (step_tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // ---------------- scan FSM ----------------
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        pending_next = pending_reg;
        case (state_reg)
            IDLE: begin
                if (step_tick || pending_reg) begin
                    state_next   = SCAN;
                    idx_next     = '0;
                    pending_next = 1'b0;
                end
            end
            SCAN: begin
                // Only one tick can be remembered; extra ones are dropped.
                if (step_tick) begin
                    pending_next = 1'b1;
                end
                if (idx_reg == IDX_LAST) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
        end
    end

    assign busy        = (state_reg == SCAN);
    assign host_ready  = (state_reg == IDLE);
    assign host_accept = host_valid && host_ready;
    assign host_ok     = ({24'b0, host_motor} < 32'(NUMBER_OF_MOTORS));

    // ---------------- visit datapath ----------------
    always_comb begin
        cur_target = target_reg[idx_reg];
        cur_sp     = sp_reg[idx_reg];

        // Highest-priority active source only.
        if (!zero_pose_button) begin
            new_target = '0;
        end else if (!release_all_button || !release_buttons[idx_reg]) begin
            new_target = saturate($signed({cur_target[31], cur_target}) - STEP33);
        end else if (!pull_buttons[idx_reg]) begin
            new_target = saturate($signed({cur_target[31], cur_target}) + STEP33);
        end else begin
            new_target = cur_target;
        end

        diff     = $signed({new_target[31], new_target}) - $signed({cur_sp[31], cur_sp});
        abs_diff = (diff < 0) ? -diff : diff;

        if ((max_step <= 0) || (abs_diff <= $signed({max_step[31], max_step}))) begin
            new_sp = new_target;
        end else if (diff > 0) begin
            new_sp = cur_sp + max_step;
        end else begin
            new_sp = cur_sp - max_step;
        end

        sp_update_next = '0;
        if ((state_reg == SCAN) && (new_sp != cur_sp)) begin
            sp_update_next[idx_reg] = 1'b1;
        end
    end

    // Host writes happen only in IDLE and visits only in SCAN, so the two
    // never target the same register in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                target_reg[i] <= '0;
                sp_reg[i]     <= '0;
            end
            sp_update_reg <= '0;
            host_err_reg  <= 1'b0;
        end else begin
            sp_update_reg <= sp_update_next;
            host_err_reg  <= host_accept && !host_ok;
            if (host_accept && host_ok) begin
                target_reg[host_motor[IDX_W-1:0]] <= saturate($signed({host_value[31], host_value}));
            end
            if (state_reg == SCAN) begin
                target_reg[idx_reg] <= new_target;
                sp_reg[idx_reg]     <= new_sp;
            end
        end
    end

    assign sp_update = sp_update_reg;
    assign host_err  = host_err_reg;

    generate
        for (genvar gi = 0; gi < NUMBER_OF_MOTORS; gi++) begin : g_sp_out
            assign sp[32*gi +: 32] = sp_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_msj_setpoint_scheduler.sv
// ---------------------------------------------------------------------------
// tb_msj_setpoint_scheduler
//
// Directed test of msj_setpoint_scheduler with a short tick period (20
// cycles) so scans come quickly. Expected values are hand-computed from
// the sequence of writes and button presses in each task.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msj_setpoint_scheduler;

    localparam int N = 6;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   host_valid;
    logic                   host_ready;
    logic [7:0]             host_motor;
    logic signed [31:0]     host_value;
    logic                   host_err;
    logic signed [31:0]     max_step;
    logic [N-1:0]           pull_buttons;
    logic [N-1:0]           release_buttons;
    logic                   release_all_button;
    logic                   zero_pose_button;
    logic [N*32-1:0]        sp;
    logic [N-1:0]           sp_update;
    logic                   busy;

    int checks = 0;
    int errors = 0;
    int upd_cnt [N];
    int scan_len;

    msj_setpoint_scheduler #(
        .NUMBER_OF_MOTORS (N),
        .CLOCK_SPEED_HZ   (20),
        .STEP_RATE_HZ     (1),
        .BUTTON_STEP      (10),
        .SP_LIMIT         (1_000_000)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .host_valid         (host_valid),
        .host_ready         (host_ready),
        .host_motor         (host_motor),
        .host_value         (host_value),
        .host_err           (host_err),
        .max_step           (max_step),
        .pull_buttons       (pull_buttons),
        .release_buttons    (release_buttons),
        .release_all_button (release_all_button),
        .zero_pose_button   (zero_pose_button),
        .sp                 (sp),
        .sp_update          (sp_update),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    function automatic logic signed [31:0] sp_of(input int i);
        return sp[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic accum();
        for (int i = 0; i < N; i++) begin
            if (sp_update[i] === 1'b1) upd_cnt[i]++;
        end
    endtask

    // One host write: waits for ready, holds valid for exactly one cycle.
    task automatic host_write(input int motor, input int value);
        int t;
        t = 0;
        while (host_ready !== 1'b1) begin
            if (t == 50) begin
                checks++; errors++;
                $display("FAIL host_write_wait: host_ready never high (got %b, required 1)", host_ready);
                return;
            end
            tick(); t++;
        end
        host_valid = 1'b1;
        host_motor = 8'(motor);
        host_value = value;
        tick();
        host_valid = 1'b0;
        $display("write motor=%0d value=%0d", motor, value);
    endtask

    // Waits for one complete scan, counting sp_update pulses and scan length.
    task automatic run_scan();
        int t;
        for (int i = 0; i < N; i++) upd_cnt[i] = 0;
        t = 0;
        while (busy !== 1'b1) begin
            if (t == 100) begin
                checks++; errors++;
                $display("FAIL scan_start: busy=%b, required 1 within 100 cycles", busy);
                return;
            end
            tick(); t++; accum();
        end
        scan_len = 1;
        t = 0;
        while (busy === 1'b1) begin
            if (t == 20) begin
                checks++; errors++;
                $display("FAIL scan_end: busy=%b, required 0 within 20 cycles", busy);
                return;
            end
            tick(); t++; accum();
            if (busy === 1'b1) scan_len++;
        end
        tick(); accum();
        checks++;
        if (scan_len !== N) begin
            errors++;
            $display("FAIL scan_length: got %0d cycles, required %0d", scan_len, N);
        end
        $display("scan done sp0=%0d sp1=%0d sp2=%0d sp3=%0d sp4=%0d sp5=%0d",
                 sp_of(0), sp_of(1), sp_of(2), sp_of(3), sp_of(4), sp_of(5));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (sp !== '0) begin errors++; $display("FAIL reset_sp: got %h, required 0", sp); end
        checks++;
        if (sp_update !== '0) begin errors++; $display("FAIL reset_sp_update: got %b, required 0", sp_update); end
        checks++;
        if (host_err !== 1'b0) begin errors++; $display("FAIL reset_host_err: got %b, required 0", host_err); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        reset = 1'b0;
        tick();
        checks++;
        if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b, required 1", host_ready); end
        $display("reset released");
    endtask

    task automatic test_host_write();
        max_step = 0;
        host_write(2, 500);
        checks++;
        if (sp_of(2) !== 32'sd0) begin errors++; $display("FAIL write_no_early_sp: got %0d, required 0", sp_of(2)); end
        run_scan();
        checks++;
        if (sp_of(2) !== 32'sd500) begin errors++; $display("FAIL write_sp2: got %0d, required 500", sp_of(2)); end
        checks++;
        if (upd_cnt[2] !== 1) begin errors++; $display("FAIL write_upd2: got %0d pulses, required 1", upd_cnt[2]); end
        checks++;
        if (upd_cnt[0] !== 0) begin errors++; $display("FAIL write_upd0: got %0d pulses, required 0", upd_cnt[0]); end
    endtask

    task automatic test_ramp();
        int exp_sp [4] = '{300, 600, 900, 1000};
        max_step = 300;
        host_write(0, 1000);
        for (int k = 0; k < 4; k++) begin
            run_scan();
            checks++;
            if (sp_of(0) !== exp_sp[k]) begin
                errors++; $display("FAIL ramp_sp0_%0d: got %0d, required %0d", k, sp_of(0), exp_sp[k]);
            end
            checks++;
            if (upd_cnt[0] !== 1) begin
                errors++; $display("FAIL ramp_upd0_%0d: got %0d pulses, required 1", k, upd_cnt[0]);
            end
        end
        run_scan();
        checks++;
        if (upd_cnt[0] !== 0) begin errors++; $display("FAIL ramp_settled_upd0: got %0d pulses, required 0", upd_cnt[0]); end
        checks++;
        if (upd_cnt[2] !== 0) begin errors++; $display("FAIL ramp_settled_upd2: got %0d pulses, required 0", upd_cnt[2]); end
    endtask

    task automatic test_buttons();
        max_step = 0;
        pull_buttons[1]    = 1'b0;
        release_buttons[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            run_scan();
            checks++;
            if (sp_of(1) !== -10 * k) begin
                errors++; $display("FAIL button_sp1_%0d: got %0d, required %0d", k, sp_of(1), -10 * k);
            end
        end
        pull_buttons[1]    = 1'b1;
        release_buttons[1] = 1'b1;

        zero_pose_button = 1'b0;
        run_scan();
        zero_pose_button = 1'b1;
        checks++;
        if (sp !== '0) begin errors++; $display("FAIL zero_pose_sp: got %h, required 0", sp); end
        checks++;
        if (upd_cnt[1] !== 1) begin errors++; $display("FAIL zero_pose_upd1: got %0d, required 1", upd_cnt[1]); end
        checks++;
        if (upd_cnt[3] !== 0) begin errors++; $display("FAIL zero_pose_upd3: got %0d, required 0", upd_cnt[3]); end

        host_write(4, -999_995);
        run_scan();
        release_all_button = 1'b0;
        run_scan();
        release_all_button = 1'b1;
        checks++;
        if (sp_of(4) !== -32'sd1_000_000) begin
            errors++; $display("FAIL release_all_sat_sp4: got %0d, required -1000000", sp_of(4));
        end
        checks++;
        if (sp_of(0) !== -32'sd10) begin errors++; $display("FAIL release_all_sp0: got %0d, required -10", sp_of(0)); end
        checks++;
        if (sp_of(5) !== -32'sd10) begin errors++; $display("FAIL release_all_sp5: got %0d, required -10", sp_of(5)); end
    endtask

    task automatic test_clamp_err();
        max_step = -1;
        host_write(3, 2_000_000);
        checks++;
        if (host_err !== 1'b0) begin errors++; $display("FAIL err_valid_write: got %b, required 0", host_err); end
        host_write(5, -2_000_000);
        host_write(7, 123);
        checks++;
        if (host_err !== 1'b1) begin errors++; $display("FAIL err_motor7: got %b, required 1", host_err); end
        tick();
        checks++;
        if (host_err !== 1'b0) begin errors++; $display("FAIL err_strobe_len: got %b, required 0", host_err); end
        host_write(6, 55);
        checks++;
        if (host_err !== 1'b1) begin errors++; $display("FAIL err_motor6: got %b, required 1", host_err); end
        host_write(9, 55);
        checks++;
        if (host_err !== 1'b1) begin errors++; $display("FAIL err_motor9: got %b, required 1", host_err); end
        run_scan();
        checks++;
        if (sp_of(3) !== 32'sd1_000_000) begin errors++; $display("FAIL clamp_pos_sp3: got %0d, required 1000000", sp_of(3)); end
        checks++;
        if (sp_of(5) !== -32'sd1_000_000) begin errors++; $display("FAIL clamp_neg_sp5: got %0d, required -1000000", sp_of(5)); end
        checks++;
        if (sp_of(1) !== -32'sd10) begin errors++; $display("FAIL bad_write_sp1: got %0d, required -10", sp_of(1)); end
        checks++;
        if (upd_cnt[1] !== 0 || upd_cnt[0] !== 0) begin
            errors++; $display("FAIL bad_write_upd: got %0d/%0d pulses, required 0/0", upd_cnt[0], upd_cnt[1]);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int low_cnt;
        max_step = 0;
        t = 0;
        while (busy !== 1'b1 && t < 100) begin tick(); t++; end
        host_valid = 1'b1;
        host_motor = 8'd0;
        host_value = 77;
        low_cnt = 0;
        t = 0;
        while (host_ready !== 1'b1 && t < 50) begin low_cnt++; tick(); t++; end
        tick();
        host_valid = 1'b0;
        $display("held write motor=0 value=77 ready_low=%0d", low_cnt);
        checks++;
        if (low_cnt !== N) begin errors++; $display("FAIL b2b_ready_low: got %0d cycles, required %0d", low_cnt, N); end
        run_scan();
        checks++;
        if (sp_of(0) !== 32'sd77) begin errors++; $display("FAIL b2b_sp0: got %0d, required 77", sp_of(0)); end
        checks++;
        if (upd_cnt[0] !== 1) begin errors++; $display("FAIL b2b_upd0: got %0d, required 1", upd_cnt[0]); end
    endtask

    task automatic test_reset_mid_scan();
        int t;
        int pulses;
        t = 0;
        while (busy !== 1'b1 && t < 100) begin tick(); t++; end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (sp !== '0) begin errors++; $display("FAIL midreset_sp: got %h, required 0", sp); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        checks++;
        if (host_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b, required 1", host_ready); end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (sp_update !== '0) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midreset_updates: got %0d pulse cycles, required 0", pulses); end
        $display("mid-scan reset done");
    endtask

    initial begin
        reset              = 1'b1;
        host_valid         = 1'b0;
        host_motor         = '0;
        host_value         = '0;
        max_step           = '0;
        pull_buttons       = '1;
        release_buttons    = '1;
        release_all_button = 1'b1;
        zero_pose_button   = 1'b1;

        test_reset();
        test_host_write();
        test_ramp();
        test_buttons();
        test_clamp_err();
        test_back_to_back();
        test_reset_mid_scan();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
